// File: rtl/scpad_pkg.sv
// scpad_pkg: shared scratchpad DRAM types and write-issuer sizing constants
package scpad_pkg;
  localparam int DRAM_ADDR_WIDTH = 32;
  localparam int DRAM_VECTOR_MASK = 4;
  localparam int DRAM_ID_WIDTH = 8;
  localparam int DRAM_WR_DEPTH = 8;
  localparam int DRAM_WR_MAX_OUTS = 4;
  typedef struct packed {
    logic valid;
    logic [63:0] wdata;
    logic [DRAM_ADDR_WIDTH-1:0] dram_addr;
    logic [DRAM_VECTOR_MASK-1:0] dram_vector_mask;
  } dram_write_req_t;
  typedef struct packed {
    logic [DRAM_ID_WIDTH-1:0] id;
    logic last;
  } dram_wr_tag_t;
endpackage

// File: rtl/scpad_sync_fifo.sv
// scpad_sync_fifo: power-of-2 synchronous FIFO with combinational head; caller never pushes full or pops empty
module scpad_sync_fifo #(
  parameter int W = 8,
  parameter int D = 4,
  parameter int CW = $clog2(D) + 1
) (
  input  logic CLK,
  input  logic nRST,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  // storage needs no reset: occupancy decides what is visible
  always_ff @(posedge CLK)
    if (push) mem_q[wptr_q] <= wdata;
  // pointers and occupancy
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  assign rdata = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/dram_write_issuer.sv
// dram_write_issuer: buffers write beats and issues them on the DRAM write channel; DRAM_WR_TIMEOUT_EN adds a ready-stall watchdog
module dram_write_issuer
  import scpad_pkg::*;
#(
  parameter int DEPTH = DRAM_WR_DEPTH,
  parameter int MAX_OUTS = DRAM_WR_MAX_OUTS,
  parameter int DATA_W = 64,
  parameter int ADDR_W = DRAM_ADDR_WIDTH,
  parameter int MASK_W = DRAM_VECTOR_MASK,
  parameter int ID_W = DRAM_ID_WIDTH
`ifdef DRAM_WR_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic CLK,
  input  logic nRST,
  input  logic req_valid,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [MASK_W-1:0] req_mask,
  input  logic [ID_W-1:0] req_id,
  input  logic req_last,
  output logic dram_be_stall,
  output logic dram_wr_valid,
  input  logic dram_wr_ready,
  output logic [ADDR_W-1:0] dram_wr_addr,
  output logic [DATA_W-1:0] dram_wr_data,
  output logic [DATA_W/8-1:0] dram_wr_strb,
  input  logic dram_wr_ack,
  output logic wr_done,
  output logic [ID_W-1:0] wr_done_id,
  output logic busy,
  output logic err
);
  localparam int BW = ADDR_W + DATA_W + MASK_W + ID_W + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTS) + 1;
  localparam int B = DATA_W / 8 / MASK_W;
  logic [CW-1:0] beat_cnt;
  logic [OW-1:0] outs;
  logic [BW-1:0] head;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_data;
  logic [MASK_W-1:0] h_mask;
  logic [ID_W-1:0] h_id, t_id;
  logic h_last, t_last;
  logic full, empty, push, issue, ack_ok, tmo_err;
  logic err_q, err_d, done_q, done_d;
  logic [ID_W-1:0] done_id_q, done_id_d;
  assign full = beat_cnt == CW'(DEPTH);
  assign empty = beat_cnt == '0;
  assign push = req_valid && !full;
  assign issue = dram_wr_valid && dram_wr_ready;
  assign ack_ok = dram_wr_ack && outs != '0;
  assign {h_addr, h_data, h_mask, h_id, h_last} = head;
  assign dram_be_stall = beat_cnt >= CW'(DEPTH - 1);
  assign dram_wr_valid = !empty && outs < OW'(MAX_OUTS);
  assign dram_wr_addr = dram_wr_valid ? h_addr : '0;
  assign dram_wr_data = dram_wr_valid ? h_data : '0;
  assign busy = !empty || outs != '0;
  assign err = err_q;
  assign wr_done = done_q;
  assign wr_done_id = done_id_q;
  scpad_sync_fifo #(.W(BW), .D(DEPTH), .CW(CW)) u_beat_fifo (
    .CLK(CLK), .nRST(nRST), .push(push), .pop(issue),
    .wdata({req_addr, req_wdata, req_mask, req_id, req_last}),
    .rdata(head), .count(beat_cnt)
  );
  // tag occupancy doubles as the outstanding-beat counter
  scpad_sync_fifo #(.W(ID_W + 1), .D(MAX_OUTS), .CW(OW)) u_tag_fifo (
    .CLK(CLK), .nRST(nRST), .push(issue), .pop(ack_ok),
    .wdata({h_id, h_last}), .rdata({t_id, t_last}), .count(outs)
  );
  // each mask element enables B consecutive byte strobes
  always_comb begin
    dram_wr_strb = '0;
    for (int i = 0; i < MASK_W; i++) dram_wr_strb[i*B +: B] = {B{h_mask[i] && dram_wr_valid}};
  end
`ifdef DRAM_WR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo_err = tmo_q == TW'(TIMEOUT);
  // watchdog counts stalled-valid cycles and saturates at the limit
  always_comb begin
    tmo_d = (dram_wr_valid && !dram_wr_ready) ? (tmo_err ? tmo_q : tmo_q + 1'b1) : '0;
  end
  // watchdog register
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign tmo_err = 1'b0;
`endif
  // sticky error and registered completion pulse on acked last beat
  always_comb begin
    err_d = err_q || (req_valid && full) || (dram_wr_ack && outs == '0) || tmo_err;
    done_d = ack_ok && t_last;
    done_id_d = done_d ? t_id : done_id_q;
  end
  // status registers
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      err_q <= 1'b0;
      done_q <= 1'b0;
      done_id_q <= '0;
    end else begin
      err_q <= err_d;
      done_q <= done_d;
      done_id_q <= done_id_d;
    end
endmodule

// File: tb/tb_dram_write_issuer.sv
// tb_dram_write_issuer: directed self-checking bench for dram_write_issuer
module tb_dram_write_issuer;
  logic CLK = 1'b0, nRST = 1'b0;
  logic req_valid = 1'b0, req_last = 1'b0;
  logic [63:0] req_wdata = '0;
  logic [31:0] req_addr = '0;
  logic [3:0] req_mask = '0;
  logic [7:0] req_id = '0;
  logic dram_be_stall, dram_wr_valid, wr_done, busy, err;
  logic dram_wr_ready = 1'b0, dram_wr_ack = 1'b0;
  logic [31:0] dram_wr_addr;
  logic [63:0] dram_wr_data;
  logic [7:0] dram_wr_strb, wr_done_id;
  int n_chk = 0, n_fail = 0, n_iss = 0, b_iss, b_done;
  logic [7:0] done_ids[$];

  dram_write_issuer dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_wdata(req_wdata),
    .req_addr(req_addr), .req_mask(req_mask), .req_id(req_id), .req_last(req_last),
    .dram_be_stall(dram_be_stall), .dram_wr_valid(dram_wr_valid), .dram_wr_ready(dram_wr_ready),
    .dram_wr_addr(dram_wr_addr), .dram_wr_data(dram_wr_data), .dram_wr_strb(dram_wr_strb),
    .dram_wr_ack(dram_wr_ack), .wr_done(wr_done), .wr_done_id(wr_done_id),
    .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (dram_wr_valid && dram_wr_ready) n_iss <= n_iss + 1;
    if (wr_done) done_ids.push_back(wr_done_id);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [63:0] d, input logic [3:0] m,
                     input logic [7:0] id, input logic l);
    req_addr = a; req_wdata = d; req_mask = m; req_id = id; req_last = l; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, dram_wr_valid, 0);
    chk({tag, "_addr"}, dram_wr_addr, 0);
    chk({tag, "_data"}, dram_wr_data, 0);
    chk({tag, "_strb"}, dram_wr_strb, 0);
    chk({tag, "_stall"}, dram_be_stall, 0);
    chk({tag, "_done"}, wr_done, 0);
    chk({tag, "_done_id"}, wr_done_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #2 chk_zero("rst");
    step();
    nRST = 1'b1;
    step();
    // single beat
    dram_wr_ready = 1'b1;
    put(32'h100, 64'hDEADBEEF_CAFEF00D, 4'b1111, 8'd3, 1'b1);
    chk("t1_valid", dram_wr_valid, 1);
    chk("t1_addr", dram_wr_addr, 64'h100);
    chk("t1_data", dram_wr_data, 64'hDEADBEEF_CAFEF00D);
    chk("t1_strb", dram_wr_strb, 8'hFF);
    chk("t1_busy_q", busy, 1);
    step();
    chk("t1_valid_after", dram_wr_valid, 0);
    chk("t1_busy_out", busy, 1);
    step();
    dram_wr_ack = 1'b1;
    step();
    dram_wr_ack = 1'b0;
    chk("t1_done", wr_done, 1);
    chk("t1_done_id", wr_done_id, 3);
    chk("t1_busy_end", busy, 0);
    step();
    chk("t1_done_pulse", wr_done, 0);
    chk("t1_err", err, 0);
    // burst fill with ready low, then overflow
    dram_wr_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      put(32'h1000 + 32'(k * 8), 64'(k), 4'hF, 8'd9, k == 7);
      if (k == 5) chk("t2_stall_6", dram_be_stall, 0);
      if (k == 6) chk("t2_stall_7", dram_be_stall, 1);
    end
    chk("t2_stall_8", dram_be_stall, 1);
    chk("t2_err_8", err, 0);
    chk("t2_head", dram_wr_addr, 64'h1000);
    put(32'h2000, 64'h99, 4'hF, 8'd9, 1'b1);
    chk("t2_overflow_err", err, 1);
    // asynchronous reset mid-burst
    nRST = 1'b0;
    #1 chk_zero("t6_async");
    step();
    nRST = 1'b1;
    step();
    chk("t6_busy_after", busy, 0);
    // sparse mask and payload hold under back-pressure
    put(32'h200, 64'h11223344_55667788, 4'b0101, 8'd7, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid", dram_wr_valid, 1);
      chk("t3_strb", dram_wr_strb, 8'h33);
      chk("t3_addr", dram_wr_addr, 64'h200);
      chk("t3_data", dram_wr_data, 64'h11223344_55667788);
      step();
    end
    dram_wr_ready = 1'b1;
    step();
    dram_wr_ready = 1'b0;
    chk("t3_popped", dram_wr_valid, 0);
    dram_wr_ack = 1'b1;
    step();
    dram_wr_ack = 1'b0;
    chk("t3_done", wr_done, 1);
    chk("t3_done_id", wr_done_id, 7);
    chk("t3_busy", busy, 0);
    // outstanding limit
    dram_wr_ready = 1'b1;
    b_iss = n_iss;
    for (int k = 0; k < 6; k++) put(32'h300 + 32'(k * 8), 64'(k), 4'hF, 8'd4, k == 5);
    step();
    chk("t4_issued_4", n_iss - b_iss, 4);
    chk("t4_valid_low", dram_wr_valid, 0);
    chk("t4_busy", busy, 1);
    dram_wr_ack = 1'b1;
    step();
    chk("t4_valid_reopen", dram_wr_valid, 1);
    step();
    chk("t4_ack_issue_valid", dram_wr_valid, 1);
    chk("t4_issued_5", n_iss - b_iss, 5);
    dram_wr_ack = 1'b0;
    step();
    chk("t4_issued_6", n_iss - b_iss, 6);
    chk("t4_valid_full", dram_wr_valid, 0);
    dram_wr_ack = 1'b1;
    step();
    step();
    step();
    chk("t4_busy_3acks", busy, 1);
    chk("t4_no_done_yet", wr_done, 0);
    step();
    dram_wr_ack = 1'b0;
    chk("t4_busy_4acks", busy, 0);
    chk("t4_done", wr_done, 1);
    chk("t4_done_id", wr_done_id, 4);
    step();
    chk("t4_err", err, 0);
    // two requests, in-order completion
    b_done = done_ids.size();
    b_iss = n_iss;
    put(32'h400, 64'hA0, 4'hF, 8'd1, 1'b0);
    put(32'h408, 64'hA1, 4'hF, 8'd1, 1'b0);
    put(32'h410, 64'hA2, 4'hF, 8'd1, 1'b1);
    put(32'h500, 64'hB0, 4'hF, 8'd2, 1'b0);
    put(32'h508, 64'hB1, 4'hF, 8'd2, 1'b1);
    step();
    step();
    dram_wr_ack = 1'b1;
    repeat (5) step();
    dram_wr_ack = 1'b0;
    step();
    step();
    chk("t5_issued", n_iss - b_iss, 5);
    chk("t5_done_count", done_ids.size() - b_done, 2);
    if (done_ids.size() >= b_done + 2) begin
      chk("t5_first_id", done_ids[b_done], 1);
      chk("t5_second_id", done_ids[b_done+1], 2);
    end
    chk("t5_busy", busy, 0);
    chk("t5_err_clean", err, 0);
    dram_wr_ack = 1'b1;
    step();
    dram_wr_ack = 1'b0;
    chk("t5_spurious_err", err, 1);
`ifdef DRAM_WR_TIMEOUT_EN
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    dram_wr_ready = 1'b0;
    put(32'h600, 64'hC0, 4'hF, 8'd5, 1'b1);
    repeat (1000) step();
    chk("t6_tmo_early", err, 0);
    repeat (30) step();
    chk("t6_tmo_err", err, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
